// File: rtl/hci_package.sv
// ---------------------------------------------------------------------------
// hci_package
// Shared types for the HCI interconnect slice:
//   hci_bank_arb_state_t    - bank arbiter sequencer states
//   hci_arb_policy_e        - arbitration policy selector
//   hci_interconnect_ctrl_t - interconnect control struct (arb_policy field)
//   idx_w()                 - index width for an N-entry vector (min 1 bit)
// ---------------------------------------------------------------------------
package hci_package;

  typedef enum logic {
    IDLE  = 1'b0,
    TS_WR = 1'b1
  } hci_bank_arb_state_t;

  typedef enum logic {
    ARB_GROUP = 1'b0,
    ARB_FLAT  = 1'b1
  } hci_arb_policy_e;

  typedef struct packed {
    hci_arb_policy_e arb_policy;
  } hci_interconnect_ctrl_t;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hci_rr_pick.sv
// ---------------------------------------------------------------------------
// hci_rr_pick
// Masked round-robin priority picker. Scans the request vector starting at
// the pointer position and wrapping around; the first active request wins.
// Ports:
//   i_req   [N]  request vector
//   i_ptr   [PW] highest-priority position (must be < N)
//   o_gnt   [N]  one-hot winner (zero when no request)
//   o_idx   [PW] winner index
//   o_valid      at least one request present
// ---------------------------------------------------------------------------
module hci_rr_pick
  import hci_package::*;
#(
  parameter  int unsigned N  = 4,
  localparam int unsigned PW = idx_w(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [PW-1:0] o_idx,
  output logic          o_valid
);

  logic [PW-1:0] w_pos;

  always_comb begin
    // NOTE: every output of this block gets a default before the scan, so no
    // path leaves a value unassigned and no latch is inferred.
    o_gnt   = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_pos   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      w_pos = PW'((32'(i_ptr) + k) % N);
      if (!o_valid && i_req[w_pos]) begin
        o_valid      = 1'b1;
        o_gnt[w_pos] = 1'b1;
        o_idx        = w_pos;
      end
    end
  end

endmodule

// File: rtl/hci_tcdm_bank_arbiter.sv
// ---------------------------------------------------------------------------
// hci_tcdm_bank_arbiter
// Shares one SRAM bank among N_CH0 high-priority and N_CH1 low-priority
// requesters. Group policy: CH0 round-robin beats CH1 round-robin unless the
// CH1 starvation escape is armed. Flat policy: one round-robin over all.
// Test-and-set runs as a locked read followed by an internal all-ones write.
// Ports:
//   clk_i, rst_i             clock, synchronous active-high reset
//   arb_policy_i             0 group priority + escape, 1 flat round-robin
//   req_i/add_i/wen_i/wdata_i/be_i/ts_i   per-requester request fields
//   gnt_o                    one-hot grant (combinational)
//   r_valid_o                one-hot response valid, one cycle after grant
//   r_data_o                 bank read data, passed straight through
//   mem_req_o/add/wen/wdata/be, mem_gnt_i, mem_rdata_i   bank port
// ---------------------------------------------------------------------------
module hci_tcdm_bank_arbiter
  import hci_package::*;
#(
  parameter  int unsigned N_CH0     = 16,
  parameter  int unsigned N_CH1     = 4,
  parameter  int unsigned AW        = 12,
  parameter  int unsigned DW        = 32,
  parameter  int unsigned BW        = 8,
  parameter  int unsigned MAX_STALL = 8,
  localparam int unsigned N         = N_CH0 + N_CH1,
  localparam int unsigned BE_W      = DW / BW
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              arb_policy_i,
  input  logic [N-1:0]      req_i,
  input  logic [N*AW-1:0]   add_i,
  input  logic [N-1:0]      wen_i,
  input  logic [N*DW-1:0]   wdata_i,
  input  logic [N*BE_W-1:0] be_i,
  input  logic [N-1:0]      ts_i,
  output logic [N-1:0]      gnt_o,
  output logic [N-1:0]      r_valid_o,
  output logic [DW-1:0]     r_data_o,
  output logic              mem_req_o,
  output logic [AW-1:0]     mem_add_o,
  output logic              mem_wen_o,
  output logic [DW-1:0]     mem_wdata_o,
  output logic [BE_W-1:0]   mem_be_o,
  input  logic              mem_gnt_i,
  input  logic [DW-1:0]     mem_rdata_i
);

  localparam int unsigned P0W = idx_w(N_CH0);
  localparam int unsigned P1W = idx_w(N_CH1);
  localparam int unsigned IW  = idx_w(N);
  localparam int unsigned CW  = $clog2(MAX_STALL + 1);

  hci_bank_arb_state_t    r_state, w_state_nxt;
  hci_interconnect_ctrl_t w_ctrl;

  logic [P0W-1:0] r_ptr0, w_idx0;
  logic [P1W-1:0] r_ptr1, w_idx1;
  logic [IW-1:0]  r_ptrf, w_idxf, w_win_idx;
  logic [N_CH0-1:0] w_oh0;
  logic [N_CH1-1:0] w_oh1;
  logic [N-1:0]   w_ohf, w_win_oh, r_valid;
  logic           w_v0, w_v1, w_vf;
  logic [CW-1:0]  r_stall_cnt, w_stall_nxt;
  logic [AW-1:0]  r_ts_addr;
  logic           w_flat, w_escape, w_pick_ch1, w_any, w_hs, w_ts_start;
  int unsigned    w_sel;

  assign w_ctrl.arb_policy = hci_arb_policy_e'(arb_policy_i);

  hci_rr_pick #(.N(N_CH0)) u_pick_ch0 (
    .i_req(req_i[N_CH0-1:0]), .i_ptr(r_ptr0),
    .o_gnt(w_oh0), .o_idx(w_idx0), .o_valid(w_v0)
  );

  hci_rr_pick #(.N(N_CH1)) u_pick_ch1 (
    .i_req(req_i[N-1:N_CH0]), .i_ptr(r_ptr1),
    .o_gnt(w_oh1), .o_idx(w_idx1), .o_valid(w_v1)
  );

  hci_rr_pick #(.N(N)) u_pick_flat (
    .i_req(req_i), .i_ptr(r_ptrf),
    .o_gnt(w_ohf), .o_idx(w_idxf), .o_valid(w_vf)
  );

  assign w_flat   = (w_ctrl.arb_policy == ARB_FLAT);
  assign w_escape = (r_stall_cnt == CW'(MAX_STALL));
  // An armed escape only matters while CH1 is actually asking.
  assign w_pick_ch1 = w_v1 && (w_escape || !w_v0);
  assign w_any      = w_flat ? w_vf : (w_v0 | w_v1);

  always_comb begin
    if (w_flat) begin
      w_win_oh  = w_ohf;
      w_win_idx = w_idxf;
    end else if (w_pick_ch1) begin
      w_win_oh  = {w_oh1, {N_CH0{1'b0}}};
      w_win_idx = IW'(w_idx1) + IW'(N_CH0);
    end else begin
      w_win_oh  = {{N_CH1{1'b0}}, w_oh0};
      w_win_idx = IW'(w_idx0);
    end
  end

  assign w_sel      = 32'(w_win_idx);
  assign w_hs       = (r_state == IDLE) && w_any && mem_gnt_i;
  assign w_ts_start = w_hs && wen_i[w_win_idx] && ts_i[w_win_idx];

  // Next state and bank-port outputs.
  always_comb begin
    w_state_nxt = r_state;
    gnt_o       = '0;
    mem_req_o   = 1'b0;
    mem_add_o   = '0;
    mem_wen_o   = 1'b1;
    mem_wdata_o = '0;
    mem_be_o    = '0;
    unique case (r_state)
      IDLE: begin
        mem_req_o   = w_any;
        mem_add_o   = add_i[w_sel*AW +: AW];
        mem_wen_o   = wen_i[w_win_idx];
        mem_wdata_o = wdata_i[w_sel*DW +: DW];
        mem_be_o    = be_i[w_sel*BE_W +: BE_W];
        gnt_o       = mem_gnt_i ? w_win_oh : '0;
        if (w_ts_start) w_state_nxt = TS_WR;
      end
      TS_WR: begin
        // Locked set half of test-and-set: nobody else is granted.
        mem_req_o   = 1'b1;
        mem_add_o   = r_ts_addr;
        mem_wen_o   = 1'b0;
        mem_wdata_o = '1;
        mem_be_o    = '1;
        if (mem_gnt_i) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Starvation counter; held clear under the flat policy.
  always_comb begin
    w_stall_nxt = r_stall_cnt;
    if (w_flat || !w_v1 || (w_hs && w_pick_ch1)) begin
      w_stall_nxt = '0;
    end else if (!w_escape) begin
      w_stall_nxt = r_stall_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: all state updates here use non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    if (rst_i) begin
      r_state     <= IDLE;
      r_ptr0      <= '0;
      r_ptr1      <= '0;
      r_ptrf      <= '0;
      r_stall_cnt <= '0;
      r_valid     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_stall_cnt <= w_stall_nxt;
      r_valid     <= gnt_o;
      if (w_hs) begin
        if (w_flat) begin
          r_ptrf <= (w_idxf == IW'(N - 1)) ? '0 : w_idxf + 1'b1;
        end else if (w_pick_ch1) begin
          r_ptr1 <= (w_idx1 == P1W'(N_CH1 - 1)) ? '0 : w_idx1 + 1'b1;
        end else begin
          r_ptr0 <= (w_idx0 == P0W'(N_CH0 - 1)) ? '0 : w_idx0 + 1'b1;
        end
      end
    end
  end

  // NOTE: the latched test-and-set address is plain datapath with no reset;
  // it is only read in TS_WR, which is entered on the same edge it is loaded.
  always_ff @(posedge clk_i) begin
    if (w_ts_start) r_ts_addr <= mem_add_o;
  end

  assign r_valid_o = r_valid;
  assign r_data_o  = mem_rdata_i;

endmodule

// File: tb/tb_hci_tcdm_bank_arbiter.sv
module tb_hci_tcdm_bank_arbiter;

  localparam int N_CH0 = 16;
  localparam int N_CH1 = 4;
  localparam int N     = N_CH0 + N_CH1;
  localparam int AW    = 12;
  localparam int DW    = 32;
  localparam int BE_W  = 4;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic              arb_policy_i = 1'b0;
  logic [N-1:0]      req_i = '0;
  logic [N*AW-1:0]   add_i = '0;
  logic [N-1:0]      wen_i = '1;
  logic [N*DW-1:0]   wdata_i = '0;
  logic [N*BE_W-1:0] be_i = '1;
  logic [N-1:0]      ts_i = '0;
  logic [N-1:0]      gnt_o, r_valid_o;
  logic [DW-1:0]     r_data_o;
  logic              mem_req_o, mem_wen_o;
  logic [AW-1:0]     mem_add_o;
  logic [DW-1:0]     mem_wdata_o;
  logic [BE_W-1:0]   mem_be_o;
  logic              mem_gnt_i = 1'b1;
  logic [DW-1:0]     mem_rdata_i = '0;

  hci_tcdm_bank_arbiter dut (
    .clk_i(clk_i), .rst_i(rst_i), .arb_policy_i(arb_policy_i),
    .req_i(req_i), .add_i(add_i), .wen_i(wen_i), .wdata_i(wdata_i),
    .be_i(be_i), .ts_i(ts_i), .gnt_o(gnt_o), .r_valid_o(r_valid_o),
    .r_data_o(r_data_o), .mem_req_o(mem_req_o), .mem_add_o(mem_add_o),
    .mem_wen_o(mem_wen_o), .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
    .mem_gnt_i(mem_gnt_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int              cyc;
    logic [N-1:0]    vec;
    logic [AW-1:0]   add;
    logic            wen;
    logic [BE_W-1:0] be;
    logic [DW-1:0]   wdata;
    logic [DW-1:0]   rdata;
  } exp_t;

  exp_t g_q[$];
  exp_t r_q[$];
  exp_t mon_g, mon_r;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  int t2_seq[6]  = '{0, 1, 2, 0, 1, 2};
  int t3_seq[11] = '{0, 1, 0, 1, 0, 1, 0, 1, 16, 0, 1};
  int t7_seq[4]  = '{2, 17, 2, 17};

  localparam logic [AW-1:0]   ADDR16 = 12'h3F0;
  localparam logic [BE_W-1:0] BE16   = 4'b0101;
  localparam logic [DW-1:0]   WD16   = 32'hCAFE_0016;

  // Bank model: read data is a fixed function of the accepted address.
  function automatic logic [DW-1:0] mkdata(input logic [AW-1:0] a);
    return 32'hDA7A_0000 | 32'(a);
  endfunction

  function automatic logic [AW-1:0] addr_of(input int i);
    return 12'h100 + 12'(i * 4);
  endfunction

  always @(posedge clk_i) begin
    cyc <= cyc + 1;
    if (mem_req_o && mem_gnt_i) mem_rdata_i <= mkdata(mem_add_o);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: compares DUT outputs against the entries queued for this cycle.
  always @(negedge clk_i) begin
    if (g_q.size() > 0 && g_q[0].cyc == cyc) begin
      mon_g = g_q.pop_front();
      check("gnt", 64'(gnt_o), 64'(mon_g.vec));
      check("mem_ctl", 64'({mem_wen_o, mem_be_o, mem_add_o}),
            64'({mon_g.wen, mon_g.be, mon_g.add}));
      if (!mon_g.wen) check("mem_wdata", 64'(mem_wdata_o), 64'(mon_g.wdata));
    end else if (gnt_o != '0) begin
      check("unexpected_gnt", 64'(gnt_o), 64'd0);
    end
    if (r_q.size() > 0 && r_q[0].cyc == cyc) begin
      mon_r = r_q.pop_front();
      check("r_valid", 64'(r_valid_o), 64'(mon_r.vec));
      if (mon_r.wen) check("r_data", 64'(r_data_o), 64'(mon_r.rdata));
    end else if (r_valid_o != '0) begin
      check("unexpected_r_valid", 64'(r_valid_o), 64'd0);
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_reqs();
    req_i = '0; ts_i = '0; wen_i = '1; add_i = '0; wdata_i = '0; be_i = '1;
  endtask

  task automatic drive(input int i, input logic [AW-1:0] a, input logic wen,
                       input logic ts, input logic [BE_W-1:0] be, input logic [DW-1:0] wd);
    req_i[i]               = 1'b1;
    add_i[i*AW +: AW]      = a;
    wen_i[i]               = wen;
    ts_i[i]                = ts;
    be_i[i*BE_W +: BE_W]   = be;
    wdata_i[i*DW +: DW]    = wd;
  endtask

  // Queue a handshake expected this cycle and its response next cycle.
  task automatic expect_hs(input int i, input logic [AW-1:0] a, input logic wen,
                           input logic [BE_W-1:0] be, input logic [DW-1:0] wd);
    exp_t e;
    e.cyc = cyc; e.vec = '0; e.vec[i] = 1'b1; e.add = a; e.wen = wen;
    e.be = be; e.wdata = wd; e.rdata = mkdata(a);
    g_q.push_back(e);
    e.cyc = cyc + 1;
    r_q.push_back(e);
  endtask

  task automatic do_reset();
    clear_reqs();
    mem_gnt_i = 1'b1;
    rst_i = 1'b1;
    step();
    check("rst_gnt", 64'(gnt_o), 64'd0);
    check("rst_r_valid", 64'(r_valid_o), 64'd0);
    check("rst_mem_req", 64'(mem_req_o), 64'd0);
    rst_i = 1'b0;
  endtask

  initial begin
    // Single read
    do_reset();
    drive(0, 12'h010, 1'b1, 1'b0, 4'hF, '0);
    expect_hs(0, 12'h010, 1'b1, 4'hF, '0);
    step();
    clear_reqs();

    // Round-robin inside CH0
    do_reset();
    for (int i = 0; i < 3; i++) drive(i, addr_of(i), 1'b1, 1'b0, 4'hF, '0);
    for (int c = 0; c < 6; c++) begin
      expect_hs(t2_seq[c], addr_of(t2_seq[c]), 1'b1, 4'hF, '0);
      step();
    end
    clear_reqs();

    // Starvation escape: CH1 write wins on the 9th cycle, then CH0 resumes
    do_reset();
    drive(0, addr_of(0), 1'b1, 1'b0, 4'hF, '0);
    drive(1, addr_of(1), 1'b1, 1'b0, 4'hF, '0);
    drive(16, ADDR16, 1'b0, 1'b0, BE16, WD16);
    for (int c = 0; c < 11; c++) begin
      if (t3_seq[c] == 16) expect_hs(16, ADDR16, 1'b0, BE16, WD16);
      else expect_hs(t3_seq[c], addr_of(t3_seq[c]), 1'b1, 4'hF, '0);
      step();
    end
    clear_reqs();

    // Test-and-set with a competing requester
    do_reset();
    drive(3, 12'h020, 1'b1, 1'b1, 4'hF, '0);
    drive(5, 12'h030, 1'b1, 1'b0, 4'hF, '0);
    expect_hs(3, 12'h020, 1'b1, 4'hF, '0);
    step();
    req_i[3] = 1'b0; ts_i[3] = 1'b0;
    @(negedge clk_i);
    check("ts_gnt", 64'(gnt_o), 64'd0);
    check("ts_mem_req", 64'(mem_req_o), 64'd1);
    check("ts_mem_ctl", 64'({mem_wen_o, mem_be_o, mem_add_o}), 64'({1'b0, 4'hF, 12'h020}));
    check("ts_mem_wdata", 64'(mem_wdata_o), 64'h0000_0000_FFFF_FFFF);
    step();
    expect_hs(5, 12'h030, 1'b1, 4'hF, '0);
    step();
    clear_reqs();

    // Bank stall for three cycles
    do_reset();
    mem_gnt_i = 1'b0;
    drive(0, 12'h040, 1'b1, 1'b0, 4'hF, '0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      check("stall_gnt", 64'(gnt_o), 64'd0);
      check("stall_mem_req", 64'(mem_req_o), 64'd1);
      check("stall_r_valid", 64'(r_valid_o), 64'd0);
      step();
    end
    mem_gnt_i = 1'b1;
    expect_hs(0, 12'h040, 1'b1, 4'hF, '0);
    step();
    clear_reqs();

    // Reset while in TS_WR (bank withholding the write)
    do_reset();
    drive(3, 12'h050, 1'b1, 1'b1, 4'hF, '0);
    expect_hs(3, 12'h050, 1'b1, 4'hF, '0);
    step();
    clear_reqs();
    mem_gnt_i = 1'b0;
    rst_i = 1'b1;
    @(negedge clk_i);
    check("tsrst_mem_req_before", 64'(mem_req_o), 64'd1);
    step();
    rst_i = 1'b0;
    mem_gnt_i = 1'b1;
    @(negedge clk_i);
    check("tsrst_mem_req", 64'(mem_req_o), 64'd0);
    check("tsrst_r_valid", 64'(r_valid_o), 64'd0);
    step();
    drive(0, 12'h060, 1'b1, 1'b0, 4'hF, '0);
    expect_hs(0, 12'h060, 1'b1, 4'hF, '0);
    step();
    clear_reqs();

    // Flat round-robin across the group boundary
    do_reset();
    arb_policy_i = 1'b1;
    drive(2, addr_of(2), 1'b1, 1'b0, 4'hF, '0);
    drive(17, addr_of(17), 1'b1, 1'b0, 4'hF, '0);
    for (int c = 0; c < 4; c++) begin
      expect_hs(t7_seq[c], addr_of(t7_seq[c]), 1'b1, 4'hF, '0);
      step();
    end
    clear_reqs();
    step();
    step();
    arb_policy_i = 1'b0;

    check("leftover_gnt", 64'(g_q.size()), 64'd0);
    check("leftover_resp", 64'(r_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
